sort_entry_sequencer: RTL and testbench
=======================================

Name: sort_entry_sequencer

Overview:
- Drives the four-number sorter's entry and sort controls from a parallel word.
- Drives the sorter's select, value and load strobe (one-hot select, 4-bit value, load on rising strobe) for each of the four slots.
- Then pulses the sort control, samples the sorter's serial display output four times and checks that the returned sequence is sorted and consistent with what was loaded.
- Used as a board self-test driver and as the active stimulus/checker end of the sorter's button protocol.

Parameters:
- SETUP_CYC, 2, cycles select/value are stable before the load strobe rises (>=1).
- PULSE_CYC, 4, cycles the load strobe is held high (>=1).
- HOLD_CYC, 2, cycles select/value stay stable after the load strobe falls (>=1).
- SORT_CYC, 4, cycles the sort strobe is held high (>=1).
- FIRST_DLY, 40, cycles from the sort strobe falling edge to the first display sample (>=1).
- SAMPLE_PER, 40, cycles between successive display samples (>=1).

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  synchronous active-high reset.
- start  input  1  begin a run; sampled only in IDLE.
- data_in  input  16  four 4-bit values; nibble k (bits 4k+3:4k) goes to slot k. Captured on accepted start.
- sel_out  output  4  one-hot slot select to sorter; slot k -> 1<<k; 0 when not loading.
- val_out  output  4  value to sorter.
- load_strobe  output  1  sorter load control.
- sort_strobe  output  1  sorter sort control.
- disp_in  input  4  sorter display output.
- busy  output  1  high from accepted start until DONE is exited.
- done  output  1  one-cycle pulse when the run completes.
- pass  output  1  result of the last run; valid when done pulses, held until the next accepted start.
- captured  output  16  four display samples; sample i in nibble i. Held until the next accepted start.

Behaviour:
- Reset (any state, mid-run included): state IDLE. All outputs 0: sel_out, val_out, load_strobe, sort_strobe, busy, done, pass, captured. Slot index, cycle counter and sample index also clear. Reset has priority over start.
- IDLE:
  - start=1 latches data_in, clears captured and pass, sets busy next cycle, slot=0, goes to SETUP.
  - start while busy is ignored (no queueing).
- SETUP: sel_out=1<<slot, val_out=nibble slot, load_strobe=0. After SETUP_CYC cycles -> STROBE.
- STROBE: sel_out and val_out unchanged, load_strobe=1 for exactly PULSE_CYC cycles -> HOLD.
- HOLD: load_strobe=0, sel_out and val_out unchanged for HOLD_CYC cycles.
  - If slot<3: slot+1 and -> SETUP.
  - If slot=3: sel_out=0, val_out=0, -> SORT.
- SORT: sort_strobe=1 for exactly SORT_CYC cycles, then 0. sel_out and load_strobe stay 0 -> WAIT.
- WAIT: count FIRST_DLY cycles from the first cycle sort_strobe is 0. On the final count, sample disp_in into nibble 0 of captured -> SAMPLE.
- SAMPLE:
  - Every SAMPLE_PER cycles, sample disp_in into the next nibble (1, 2, 3).
  - After nibble 3 -> CHECK.
- CHECK (1 cycle):
  - pass=1 iff captured nibbles are non-decreasing (n0<=n1<=n2<=n3) and the 6-bit unsigned sum of captured nibbles equals the 6-bit sum of latched data nibbles.
  - Max sum is 60, so 6 bits never overflow.
  - -> DONE.
- DONE (1 cycle): done=1, busy=0 on the following cycle -> IDLE.
- Invariants:
  - load_strobe and sort_strobe are never high in the same cycle.
  - sel_out is always 0 or one-hot.
  - sel_out and val_out never change while load_strobe=1, nor in the cycle it falls.
- Latency: the first load_strobe rise occurs SETUP_CYC+1 cycles after start is sampled.
- Duplicate values are legal; equal neighbours satisfy the ordering check.

Test Plan:
- Reset then start with data_in=0x3A17 (slots 7,1,A,3), disp_in modelled by a behavioural sorter:
  - sel_out sequence 1,2,4,8 with val_out 7,1,A,3.
  - 4 load pulses of 4 cycles each, then one sort pulse.
  - captured=0xA731, pass=1, single done pulse.
- data_in=0x5555: all loads 5; captured=0x5555, pass=1 (equal-neighbour case).
- data_in=0x3A17 with disp_in forced to stream 7,1,A,3: captured=0x3A17, pass=0 (order fails).
- data_in=0x3A17 with disp_in stream 1,3,7,B: ordered but sum 22 != 21, so pass=0.
- Assert start again during STROBE of slot 2: ignored, run completes unchanged. Then assert rst during SAMPLE: next cycle all outputs 0, and a fresh start runs normally.
- Check strobe timing: val_out/sel_out stable for 2 cycles before, 4 during and 2 after each load_strobe high; sort_strobe never overlaps load_strobe.

Source files
------------

// File: rtl/sort_entry_sequencer.sv
// sort_entry_sequencer
// Loads four 4-bit values into a four-number sorter over its button protocol
// (one-hot select, value, load strobe), pulses the sort control, samples the
// sorter's serial display four times and checks the result.
//
// Ports:
//   clk          clock, all state changes on the rising edge
//   rst          synchronous active-high reset
//   start        begin a run (only looked at while idle)
//   data_in      four nibbles, nibble k goes to slot k, latched on start
//   sel_out      one-hot slot select to the sorter, 0 when not loading
//   val_out      value presented to the sorter
//   load_strobe  sorter load control
//   sort_strobe  sorter sort control
//   disp_in      sorter display output
//   busy         high from accepted start until the done cycle is left
//   done         one-cycle pulse at the end of a run
//   pass         result of the last run
//   captured     the four display samples, sample i in nibble i
module sort_entry_sequencer #(
   parameter int SETUP_CYC  = 2,
   parameter int PULSE_CYC  = 4,
   parameter int HOLD_CYC   = 2,
   parameter int SORT_CYC   = 4,
   parameter int FIRST_DLY  = 40,
   parameter int SAMPLE_PER = 40
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [15:0] data_in,
   output logic [3:0]  sel_out,
   output logic [3:0]  val_out,
   output logic        load_strobe,
   output logic        sort_strobe,
   input  logic [3:0]  disp_in,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic [15:0] captured
);

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   localparam int CNT_MAX = max2(max2(max2(SETUP_CYC, PULSE_CYC), max2(HOLD_CYC, SORT_CYC)),
                                 max2(FIRST_DLY, SAMPLE_PER));
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYC - 1);
   localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYC - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYC - 1);
   localparam logic [CNT_W-1:0] SORT_LAST  = CNT_W'(SORT_CYC - 1);
   localparam logic [CNT_W-1:0] FIRST_LAST = CNT_W'(FIRST_DLY - 1);
   localparam logic [CNT_W-1:0] PER_LAST   = CNT_W'(SAMPLE_PER - 1);

   typedef enum logic [3:0] {
      S_IDLE,
      S_SETUP,
      S_STROBE,
      S_HOLD,
      S_SORT,
      S_WAIT,
      S_SAMPLE,
      S_CHECK,
      S_DONE
   } state_t;

   state_t           state, state_nxt;
   logic [1:0]       slot, slot_nxt;
   logic [1:0]       sidx, sidx_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [15:0]      data_reg, data_nxt;
   logic [15:0]      captured_nxt;
   logic             pass_nxt;
   logic [3:0]       sel_nxt, val_nxt;
   logic             load_nxt, sort_nxt, busy_nxt, done_nxt;
   logic             loading;
   logic             ordered;
   logic [5:0]       cap_sum, dat_sum;

   // Result check: the display samples must be non-decreasing and carry the
   // same total as the loaded values (catches dropped or duplicated entries).
   assign ordered = (captured[3:0]  <= captured[7:4])  &&
                    (captured[7:4]  <= captured[11:8]) &&
                    (captured[11:8] <= captured[15:12]);
   assign cap_sum = 6'(captured[3:0]) + 6'(captured[7:4]) +
                    6'(captured[11:8]) + 6'(captured[15:12]);
   assign dat_sum = 6'(data_reg[3:0]) + 6'(data_reg[7:4]) +
                    6'(data_reg[11:8]) + 6'(data_reg[15:12]);

   // Next-state logic. Every timed phase runs its counter from 0 to its last
   // value; the counter restarts at 0 on each phase change. Outputs are
   // derived from the next state so they line up with the state register.
   always_comb begin
      state_nxt    = state;
      slot_nxt     = slot;
      sidx_nxt     = sidx;
      cnt_nxt      = cnt + 1'b1;
      data_nxt     = data_reg;
      captured_nxt = captured;
      pass_nxt     = pass;
      case (state)
         S_IDLE: begin
            cnt_nxt = '0;
            if (start) begin
               data_nxt     = data_in;
               captured_nxt = '0;
               pass_nxt     = 1'b0;
               slot_nxt     = '0;
               sidx_nxt     = '0;
               state_nxt    = S_SETUP;
            end
         end
         S_SETUP: begin
            if (cnt == SETUP_LAST) begin
               cnt_nxt   = '0;
               state_nxt = S_STROBE;
            end
         end
         S_STROBE: begin
            if (cnt == PULSE_LAST) begin
               cnt_nxt   = '0;
               state_nxt = S_HOLD;
            end
         end
         S_HOLD: begin
            if (cnt == HOLD_LAST) begin
               cnt_nxt = '0;
               if (slot == 2'd3) begin
                  state_nxt = S_SORT;
               end else begin
                  slot_nxt  = slot + 2'd1;
                  state_nxt = S_SETUP;
               end
            end
         end
         S_SORT: begin
            if (cnt == SORT_LAST) begin
               cnt_nxt   = '0;
               state_nxt = S_WAIT;
            end
         end
         S_WAIT: begin
            if (cnt == FIRST_LAST) begin
               cnt_nxt           = '0;
               captured_nxt[3:0] = disp_in;
               sidx_nxt          = 2'd1;
               state_nxt         = S_SAMPLE;
            end
         end
         S_SAMPLE: begin
            if (cnt == PER_LAST) begin
               cnt_nxt                          = '0;
               captured_nxt[{sidx, 2'b00} +: 4] = disp_in;
               sidx_nxt                         = sidx + 2'd1;
               if (sidx == 2'd3) begin
                  state_nxt = S_CHECK;
               end
            end
         end
         S_CHECK: begin
            cnt_nxt   = '0;
            pass_nxt  = ordered && (cap_sum == dat_sum);
            state_nxt = S_DONE;
         end
         S_DONE: begin
            cnt_nxt   = '0;
            state_nxt = S_IDLE;
         end
         default: begin
            cnt_nxt   = '0;
            state_nxt = S_IDLE;
         end
      endcase

      loading  = (state_nxt == S_SETUP) || (state_nxt == S_STROBE) || (state_nxt == S_HOLD);
      sel_nxt  = loading ? (4'b0001 << slot_nxt) : 4'b0000;
      val_nxt  = loading ? data_nxt[{slot_nxt, 2'b00} +: 4] : 4'b0000;
      load_nxt = (state_nxt == S_STROBE);
      sort_nxt = (state_nxt == S_SORT);
      done_nxt = (state_nxt == S_DONE);
      busy_nxt = (state_nxt != S_IDLE);
   end

   // State and output registers; reset clears everything, including a run
   // that is in progress.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         slot        <= '0;
         sidx        <= '0;
         cnt         <= '0;
         data_reg    <= '0;
         captured    <= '0;
         pass        <= 1'b0;
         sel_out     <= '0;
         val_out     <= '0;
         load_strobe <= 1'b0;
         sort_strobe <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
      end else begin
         state       <= state_nxt;
         slot        <= slot_nxt;
         sidx        <= sidx_nxt;
         cnt         <= cnt_nxt;
         data_reg    <= data_nxt;
         captured    <= captured_nxt;
         pass        <= pass_nxt;
         sel_out     <= sel_nxt;
         val_out     <= val_nxt;
         load_strobe <= load_nxt;
         sort_strobe <= sort_nxt;
         busy        <= busy_nxt;
         done        <= done_nxt;
      end
   end

endmodule

// File: tb/tb_sort_entry_sequencer.sv
// tb_sort_entry_sequencer
// Drives sort_entry_sequencer with a behavioural four-number sorter on the
// display side (or a forced display stream) and compares every cycle of the
// control outputs, plus the captured samples and pass flag, against a model
// built from the phase durations.
module tb_sort_entry_sequencer;

   localparam int SETUP_CYC  = 2;
   localparam int PULSE_CYC  = 4;
   localparam int HOLD_CYC   = 2;
   localparam int SORT_CYC   = 4;
   localparam int FIRST_DLY  = 40;
   localparam int SAMPLE_PER = 40;

   logic        clk;
   logic        rst;
   logic        start;
   logic [15:0] data_in;
   logic [3:0]  sel_out;
   logic [3:0]  val_out;
   logic        load_strobe;
   logic        sort_strobe;
   logic [3:0]  disp_in;
   logic        busy;
   logic        done;
   logic        pass;
   logic [15:0] captured;

   int total;
   int bad;

   typedef struct {
      string       name;
      logic [15:0] data;
      bit          forced;
      logic [15:0] stream;
      logic [15:0] exp_cap;
      bit          exp_pass;
   } vec_t;

   vec_t vecs [4];

   sort_entry_sequencer #(
      .SETUP_CYC (SETUP_CYC),
      .PULSE_CYC (PULSE_CYC),
      .HOLD_CYC  (HOLD_CYC),
      .SORT_CYC  (SORT_CYC),
      .FIRST_DLY (FIRST_DLY),
      .SAMPLE_PER(SAMPLE_PER)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .data_in    (data_in),
      .sel_out    (sel_out),
      .val_out    (val_out),
      .load_strobe(load_strobe),
      .sort_strobe(sort_strobe),
      .disp_in    (disp_in),
      .busy       (busy),
      .done       (done),
      .pass       (pass),
      .captured   (captured)
   );

   // Free-running clock, 10 time units per period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s got=%h want=%h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] sort_nibbles(input logic [15:0] w);
      logic [3:0]  a [4];
      logic [3:0]  t;
      logic [15:0] r;
      for (int i = 0; i < 4; i++) a[i] = w[4*i +: 4];
      for (int i = 0; i < 3; i++) begin
         for (int j = 0; j < 3 - i; j++) begin
            if (a[j] > a[j+1]) begin
               t      = a[j];
               a[j]   = a[j+1];
               a[j+1] = t;
            end
         end
      end
      r = '0;
      for (int i = 0; i < 4; i++) r[4*i +: 4] = a[i];
      return r;
   endfunction

   function automatic bit model_pass(input logic [15:0] cap, input logic [15:0] d);
      int sc;
      int sd;
      bit ord;
      sc  = 0;
      sd  = 0;
      ord = 1'b1;
      for (int i = 0; i < 4; i++) begin
         sc += int'(cap[4*i +: 4]);
         sd += int'(d[4*i +: 4]);
      end
      for (int i = 0; i < 3; i++) begin
         if (cap[4*i +: 4] > cap[4*i+4 +: 4]) ord = 1'b0;
      end
      return ord && (sc == sd);
   endfunction

   function automatic int onehot_idx(input logic [3:0] s);
      case (s)
         4'b0010: return 1;
         4'b0100: return 2;
         4'b1000: return 3;
         default: return 0;
      endcase
   endfunction

   // Display shown t cycles after the sort strobe fell: element i is on
   // display for one full sample period around its sampling instant.
   function automatic logic [3:0] disp_for(input logic [15:0] s, input int t);
      int base;
      int i;
      base = FIRST_DLY - 1;
      if (t < base) return 4'hF;
      i = (t - base) / SAMPLE_PER;
      if (i > 3) return 4'hF;
      return s[4*i +: 4];
   endfunction

   // One complete run. The expected waveform is the concatenation of the
   // protocol phases; the display side is a sorter that latches on load
   // rising edges and sorts on the sort strobe falling edge.
   task automatic applyStimulus(input string name, input logic [15:0] d, input bit forced,
                                input logic [15:0] fstream, input int inj_cycle,
                                input logic [15:0] exp_cap, input bit exp_pass);
      logic [11:0] q [$];
      logic [3:0]  stored [4];
      logic [15:0] stream;
      logic [15:0] packed_store;
      logic        prev_load;
      logic        prev_sort;
      logic [3:0]  s;
      logic [3:0]  v;
      bit          fell;
      int          t;

      q = {};
      for (int k = 0; k < 4; k++) begin
         s = 4'b0001 << k;
         v = d[4*k +: 4];
         for (int i = 0; i < SETUP_CYC; i++) q.push_back({4'b1000, s, v});
         for (int i = 0; i < PULSE_CYC; i++) q.push_back({4'b1010, s, v});
         for (int i = 0; i < HOLD_CYC;  i++) q.push_back({4'b1000, s, v});
      end
      for (int i = 0; i < SORT_CYC; i++) q.push_back(12'b1001_0000_0000);
      for (int i = 0; i < FIRST_DLY + 3*SAMPLE_PER + 1; i++) q.push_back(12'b1000_0000_0000);
      q.push_back(12'b1100_0000_0000);
      q.push_back(12'b0000_0000_0000);

      for (int i = 0; i < 4; i++) stored[i] = 4'hE;
      stream    = fstream;
      prev_load = 1'b0;
      prev_sort = 1'b0;
      fell      = 1'b0;
      t         = 0;
      disp_in   = 4'hF;
      data_in   = d;
      start     = 1'b1;
      step();
      start   = 1'b0;
      data_in = ~d;

      for (int c = 0; c < q.size(); c++) begin
         checkOutput($sformatf("%s trace cycle %0d", name, c + 1),
                     {52'b0, busy, done, load_strobe, sort_strobe, sel_out, val_out},
                     {52'b0, q[c]});
         if (q[c][10]) begin
            checkOutput({name, " captured"}, {48'b0, captured}, {48'b0, exp_cap});
            checkOutput({name, " pass"}, {63'b0, pass}, {63'b0, exp_pass});
         end
         if (load_strobe && !prev_load) stored[onehot_idx(sel_out)] = val_out;
         if (prev_sort && !sort_strobe) begin
            fell = 1'b1;
            t    = 0;
            if (!forced) begin
               for (int i = 0; i < 4; i++) packed_store[4*i +: 4] = stored[i];
               stream = sort_nibbles(packed_store);
            end
         end else if (fell) begin
            t++;
         end
         disp_in   = fell ? disp_for(stream, t) : 4'hF;
         prev_load = load_strobe;
         prev_sort = sort_strobe;
         if (c + 1 == inj_cycle) begin
            start   = 1'b1;
            data_in = 16'h0000;
         end else begin
            start = 1'b0;
         end
         step();
      end
      checkOutput({name, " captured held"}, {48'b0, captured}, {48'b0, exp_cap});
      checkOutput({name, " pass held"}, {63'b0, pass}, {63'b0, exp_pass});
   endtask

   initial begin
      logic [15:0] d;
      logic [15:0] fs;
      logic [15:0] ec;
      bit          forced;
      bit          ep;

      total = 0;
      bad   = 0;

      vecs[0] = '{name: "sorted 3A17", data: 16'h3A17, forced: 1'b0, stream: 16'h0000,
                  exp_cap: 16'hA731, exp_pass: 1'b1};
      vecs[1] = '{name: "equal 5555", data: 16'h5555, forced: 1'b0, stream: 16'h0000,
                  exp_cap: 16'h5555, exp_pass: 1'b1};
      vecs[2] = '{name: "unordered 3A17", data: 16'h3A17, forced: 1'b1, stream: 16'h3A17,
                  exp_cap: 16'h3A17, exp_pass: 1'b0};
      vecs[3] = '{name: "bad sum 3A17", data: 16'h3A17, forced: 1'b1, stream: 16'hB731,
                  exp_cap: 16'hB731, exp_pass: 1'b0};

      // Reset with start held high: reset must win.
      rst     = 1'b1;
      start   = 1'b1;
      data_in = 16'h1234;
      disp_in = 4'h0;
      repeat (3) step();
      checkOutput("reset state",
                  {33'b0, busy, done, load_strobe, sort_strobe, sel_out, val_out, pass, captured},
                  64'd0);
      rst   = 1'b0;
      start = 1'b0;
      step();
      checkOutput("idle after reset", {63'b0, busy}, 64'd0);

      for (int i = 0; i < 4; i++) begin
         applyStimulus(vecs[i].name, vecs[i].data, vecs[i].forced, vecs[i].stream, 0,
                       vecs[i].exp_cap, vecs[i].exp_pass);
      end

      // A second start during the load pulse of slot 2 must be ignored.
      applyStimulus("start during strobe", 16'h3A17, 1'b0, 16'h0000, 20, 16'hA731, 1'b1);

      // Reset in the middle of the sampling phase.
      data_in = 16'h3A17;
      disp_in = 4'hF;
      start   = 1'b1;
      step();
      start = 1'b0;
      repeat (99) step();
      checkOutput("busy before mid reset", {63'b0, busy}, 64'd1);
      rst = 1'b1;
      step();
      checkOutput("mid-run reset",
                  {33'b0, busy, done, load_strobe, sort_strobe, sel_out, val_out, pass, captured},
                  64'd0);
      rst = 1'b0;
      step();
      checkOutput("idle after mid reset", {63'b0, busy}, 64'd0);
      applyStimulus("fresh after reset", 16'h0F96, 1'b0, 16'h0000, 0, 16'hF960, 1'b1);

      for (int r = 0; r < 6; r++) begin
         d      = 16'($urandom);
         fs     = 16'($urandom);
         forced = 1'($urandom_range(0, 1));
         ec     = forced ? fs : sort_nibbles(d);
         ep     = model_pass(ec, d);
         applyStimulus($sformatf("random %0d", r), d, forced, fs, 0, ec, ep);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
